// File: rtl/fifo_uart_tx_drain.sv
// Drains a first-word-fall-through capture FIFO onto a UART 8N1 line.
// Pops one byte per frame and shifts it out LSB first behind a start bit.
`timescale 1ns/1ps
module fifo_uart_tx_drain #(
    parameter int BAUD_DIV  = 104,
    parameter int STOP_BITS = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [7:0]           fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] tx_count
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]        BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]        BAUD_ONE  = BW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic                 STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [BW-1:0]          baud_r;
    logic [2:0]             bit_r;
    logic                   stop_r;
    logic [7:0]             shift_r;
    logic                   tx_r;
    logic                   busy_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   pop_s;
    logic                   baud_end_s;

    // Gating with rst keeps the pop strobe low while reset is held.
    assign pop_s      = rst & (state_r == IDLE) & en & ~fifo_empty;
    assign baud_end_s = (baud_r == BAUD_LAST);

    assign fifo_rd_en = pop_s;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign tx_count   = count_r;

    // Frame sequencer: baud timing, bit shifting and the completed-frame count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            stop_r  <= 1'b0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            count_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r <= '0;
                    bit_r  <= 3'd0;
                    stop_r <= 1'b0;
                    if (pop_s) begin
                        shift_r <= fifo_data;
                        state_r <= START;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        baud_r  <= '0;
                        state_r <= DATA;
                        tx_r    <= shift_r[0];
                    end else begin
                        baud_r  <= baud_r + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_r <= '0;
                        if (bit_r == 3'd7) begin
                            bit_r   <= 3'd0;
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            // Next bit goes out directly from shift_r[1] so tx stays registered.
                            bit_r   <= bit_r + 3'd1;
                            shift_r <= {1'b0, shift_r[7:1]};
                            tx_r    <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_end_s) begin
                        baud_r <= '0;
                        if (stop_r == STOP_LAST) begin
                            stop_r  <= 1'b0;
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            count_r <= count_r + CNT_ONE;
                        end else begin
                            stop_r  <= 1'b1;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    baud_r  <= '0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: two instances (1 and 2 stop bits) fed by FIFO models
// and checked every cycle against a frame-timing reference model.
`timescale 1ns/1ps
module tb_fifo_uart_tx_drain;

    localparam int BD = 4;

    typedef struct {
        int         lane;
        logic [7:0] data;
        logic [10:0] frame;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  [2];
    logic        fe  [2] = '{1'b1, 1'b1};
    logic [7:0]  fd  [2] = '{8'h00, 8'h00};
    logic        rd  [2];
    logic        txo [2];
    logic        bsy [2];
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    always #5 clk = ~clk;

    fifo_uart_tx_drain #(.BAUD_DIV(BD), .STOP_BITS(1), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .en(en[0]), .fifo_data(fd[0]), .fifo_empty(fe[0]),
        .fifo_rd_en(rd[0]), .tx(txo[0]), .busy(bsy[0]), .tx_count(cnt_a));

    fifo_uart_tx_drain #(.BAUD_DIV(BD), .STOP_BITS(2), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .en(en[1]), .fifo_data(fd[1]), .fifo_empty(fe[1]),
        .fifo_rd_en(rd[1]), .tx(txo[1]), .busy(bsy[1]), .tx_count(cnt_b));

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] mem [2][256];
    int         head [2] = '{0, 0};
    int         tail [2] = '{0, 0};
    int         pop_t [2] = '{-100000, -100000};
    logic [7:0] pb [2] = '{8'h00, 8'h00};
    int         exp_cnt [2] = '{0, 0};
    int         m_o, m_len;
    logic       m_act, m_tx, m_rd;

    function automatic int stop_of(input int l);
        return (l == 0) ? 1 : 2;
    endfunction

    function automatic int mask_of(input int l);
        return (l == 0) ? 15 : 65535;
    endfunction

    function automatic int cnt_of(input int l);
        return (l == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction

    task automatic check(input string name, input int l, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d cycle %0d: got %0d expected %0d", name, l, cyc, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int l, input logic [7:0] b);
        mem[l][tail[l] % 256] = b;
        tail[l] = tail[l] + 1;
    endtask

    task automatic wait_pop(input int l, input int limit, output int waited);
        waited = -1;
        #1;
        for (int i = 0; i < limit; i++) begin
            if (rd[l] === 1'b1) begin
                waited = i;
                break;
            end
            cycles(1);
        end
        if (waited < 0) check("pop_timeout", l, 0, 1);
    endtask

    // FIFO model: registered FWFT head, popped on the edge that ends a pop cycle.
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (rd[l] === 1'b1) begin
                pop_t[l] = cyc;
                pb[l]    = fd[l];
                head[l]  = head[l] + 1;
            end
            fe[l] <= (head[l] == tail[l]);
            fd[l] <= mem[l][head[l] % 256];
        end
        cyc = cyc + 1;
    end

    // Reference: expected line level, busy, pop strobe and count from the cycle offset since the pop.
    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            m_len = (9 + stop_of(l)) * BD;
            if (rst !== 1'b1) begin
                pop_t[l]   = -100000;
                exp_cnt[l] = 0;
            end
            m_o = cyc - pop_t[l];
            if (m_o == m_len + 1) exp_cnt[l] = (exp_cnt[l] + 1) & mask_of(l);
            m_act = (m_o >= 1) && (m_o <= m_len);
            if (!m_act)            m_tx = 1'b1;
            else if (m_o <= BD)    m_tx = 1'b0;
            else if (m_o <= 9*BD)  m_tx = pb[l][(m_o - 1) / BD - 1];
            else                   m_tx = 1'b1;
            m_rd = (rst === 1'b1) && !m_act && (en[l] === 1'b1) && (fe[l] === 1'b0);
            check("tx",       l, int'(txo[l]), int'(m_tx));
            check("busy",     l, int'(bsy[l]), int'(m_act));
            check("rd_en",    l, int'(rd[l]),  int'(m_rd));
            check("tx_count", l, cnt_of(l),    exp_cnt[l]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int   w, c0, m, len, nb, l;

        vecs[0] = '{0, 8'hA5, 11'b0_1_10100101_0};
        vecs[1] = '{0, 8'h01, 11'b0_1_00000001_0};
        vecs[2] = '{1, 8'h80, 11'b11_10000000_0};
        vecs[3] = '{1, 8'h5A, 11'b11_01011010_0};

        en[0] = 1'b0;
        en[1] = 1'b0;
        cycles(3);
        for (int i = 0; i < 2; i++) begin
            check("reset_tx",    i, int'(txo[i]), 1);
            check("reset_busy",  i, int'(bsy[i]), 0);
            check("reset_count", i, cnt_of(i), 0);
        end
        rst = 1'b1;

        // Idle with an empty FIFO: nothing may happen.
        en[0] = 1'b1;
        en[1] = 1'b1;
        cycles(2000);
        for (int i = 0; i < 2; i++) begin
            check("idle_tx",    i, int'(txo[i]), 1);
            check("idle_busy",  i, int'(bsy[i]), 0);
            check("idle_count", i, cnt_of(i), 0);
        end
        en[0] = 1'b0;
        en[1] = 1'b0;

        // Single frames from the vector table, sampled mid-bit.
        for (int v = 0; v < 4; v++) begin
            l = vecs[v].lane;
            push(l, vecs[v].data);
            en[l] = 1'b1;
            wait_pop(l, 20, w);
            c0  = cnt_of(l);
            len = (9 + stop_of(l)) * BD;
            nb  = 9 + stop_of(l);
            cycles(1);
            en[l] = 1'b0;
            m = 1;
            for (int k = 0; k < nb; k++) begin
                cycles(2 + k*BD - m);
                m = 2 + k*BD;
                check("frame_bit", l, int'(txo[l]), int'(vecs[v].frame[k]));
            end
            cycles(len - m);
            check("busy_last", l, int'(bsy[l]), 1);
            cycles(1);
            check("busy_fall", l, int'(bsy[l]), 0);
            check("count_inc", l, cnt_of(l), (c0 + 1) & mask_of(l));
        end

        // Three queued bytes, two stop bits: back-to-back pops 45 cycles apart.
        push(1, 8'h00);
        push(1, 8'hFF);
        push(1, 8'h55);
        en[1] = 1'b1;
        wait_pop(1, 20, w);
        c0 = cnt_of(1);
        for (int j = 0; j < 2; j++) begin
            cycles(1);
            wait_pop(1, 60, w);
            check("pop_gap", 1, w + 1, 45);
        end
        cycles(50);
        check("queued_count", 1, cnt_of(1), c0 + 3);
        en[1] = 1'b0;

        // en dropped mid-frame: current frame finishes, no further pop until re-enabled.
        push(0, 8'h3C);
        push(0, 8'hC3);
        c0 = cnt_of(0);
        en[0] = 1'b1;
        wait_pop(0, 20, w);
        cycles(10);
        en[0] = 1'b0;
        cycles(60);
        check("en_drop_count", 0, cnt_of(0), (c0 + 1) & 15);
        check("en_drop_left",  0, tail[0] - head[0], 1);
        en[0] = 1'b1;
        wait_pop(0, 5, w);
        cycles(45);
        check("en_resume_count", 0, cnt_of(0), (c0 + 2) & 15);
        en[0] = 1'b0;

        // Reset mid-frame: line idles at once, the in-flight byte is dropped.
        push(1, 8'h96);
        push(1, 8'h69);
        en[1] = 1'b1;
        wait_pop(1, 20, w);
        cycles(20);
        rst = 1'b0;
        #1;
        check("rst_tx",      1, int'(txo[1]), 1);
        check("rst_busy",    1, int'(bsy[1]), 0);
        check("rst_count_b", 1, cnt_of(1), 0);
        check("rst_count_a", 0, cnt_of(0), 0);
        cycles(2);
        rst = 1'b1;
        wait_pop(1, 5, w);
        cycles(50);
        check("post_rst_count", 1, cnt_of(1), 1);
        check("post_rst_left",  1, tail[1] - head[1], 0);
        en[1] = 1'b0;

        // 17 frames on the 4-bit counter wrap it to 1.
        for (int i = 0; i < 17; i++) push(0, 8'(i * 13));
        en[0] = 1'b1;
        cycles(17 * 41 + 20);
        en[0] = 1'b0;
        check("wrap_count", 0, cnt_of(0), 1);

        // Random traffic and enable toggling; the per-cycle model does the checking.
        for (int it = 0; it < 150; it++) begin
            l = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin
                if (tail[l] - head[l] < 4) push(l, 8'($urandom_range(0, 255)));
            end
            en[$urandom_range(0, 1)] = 1'($urandom_range(0, 1));
            cycles(int'($urandom_range(1, 60)));
        end
        en[0] = 1'b1;
        en[1] = 1'b1;
        cycles(400);
        check("drained", 0, tail[0] - head[0], 0);
        check("drained", 1, tail[1] - head[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
